// File: rtl/drive_sequencer.sv
// drive_sequencer: arms the gate driver, runs the generator open-loop,
// hands off to the measured period, and enforces on/off time and faults.
// Optional: define PERIOD_RANGE_CHECK_EN to fault on out-of-range periods.
module drive_sequencer #(
  parameter int unsigned ON_CYCLES_MAX  = 20000,
  parameter int unsigned OFF_CYCLES_MIN = 200000,
  parameter int unsigned ARM_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT   = 2000,
  parameter int unsigned PERIOD_MIN     = 20,
  parameter int unsigned PERIOD_MAX     = 200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fire,
  input  logic        fault_clear,
  input  logic [31:0] period_in,
  input  logic        period_valid,
  output logic        driver_enable,
  output logic        gen_run,
  output logic        period_set,
  output logic [31:0] period_out,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_OPEN,
    S_LOCK,
    S_COOL,
    S_FAULT
  } state_t;

  localparam logic [31:0] ON_LAST   = 32'(ON_CYCLES_MAX - 1);
  localparam logic [31:0] OFF_LAST  = 32'(OFF_CYCLES_MIN - 1);
  localparam logic [31:0] ARM_LAST  = 32'(ARM_CYCLES - 1);
  localparam logic [31:0] LOCK_LAST = 32'(LOCK_TIMEOUT - 1);

  state_t      state;
  state_t      state_d;
  logic [31:0] on_cnt;
  logic [31:0] ph_cnt;
  logic        accept;
  logic        range_bad;
  logic        stop;
  logic        in_burst;
  logic        run_d;
  logic [1:0]  code_d;

`ifdef PERIOD_RANGE_CHECK_EN
  assign range_bad = (period_in < 32'(PERIOD_MIN)) ||
                     (period_in > 32'(PERIOD_MAX));
`else
  assign range_bad = 1'b0;
`endif

  assign in_burst = (state == S_ARM) || (state == S_OPEN) ||
                    (state == S_LOCK);
  assign stop     = !fire || (on_cnt >= ON_LAST);
  assign run_d    = (state_d == S_OPEN) || (state_d == S_LOCK);

  // Next state, period acceptance and fault code; faults beat stop,
  // stop beats a period update, a period update beats lock timeout.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    code_d  = (state == S_FAULT) ? fault_code : 2'd0;
    unique case (state)
      S_IDLE: begin
        if (fire) state_d = S_ARM;
      end
      S_ARM: begin
        if (stop) state_d = S_COOL;
        else if (ph_cnt >= ARM_LAST) state_d = S_OPEN;
      end
      S_OPEN, S_LOCK: begin
        if (period_valid && range_bad) begin
          state_d = S_FAULT;
          code_d  = 2'd2;
        end else if ((state == S_OPEN) && !period_valid &&
                     (ph_cnt >= LOCK_LAST)) begin
          state_d = S_FAULT;
          code_d  = 2'd1;
        end else if (stop) begin
          state_d = S_COOL;
        end else if (period_valid) begin
          state_d = S_LOCK;
          accept  = 1'b1;
        end
      end
      S_COOL: begin
        if (ph_cnt >= OFF_LAST) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clear) begin
          state_d = S_COOL;
          code_d  = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and saturating phase/on-time counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      ph_cnt <= '0;
      on_cnt <= '0;
    end else begin
      state <= state_d;
      if (state_d != state) ph_cnt <= '0;
      else if (ph_cnt != '1) ph_cnt <= ph_cnt + 32'd1;
      if ((state == S_IDLE) && (state_d == S_ARM)) on_cnt <= '0;
      else if (in_burst && (on_cnt != '1)) on_cnt <= on_cnt + 32'd1;
    end
  end

  // Registered outputs decoded from the upcoming state.
  always_ff @(posedge clock) begin
    if (reset) begin
      driver_enable <= 1'b0;
      gen_run       <= 1'b0;
      period_set    <= 1'b0;
      period_out    <= '0;
      busy          <= 1'b0;
      fault         <= 1'b0;
      fault_code    <= 2'd0;
    end else begin
      driver_enable <= run_d || (state_d == S_ARM);
      gen_run       <= run_d;
      period_set    <= accept;
      if (accept) period_out <= period_in;
      else if (!run_d) period_out <= '0;
      busy          <= (state_d != S_IDLE) && (state_d != S_FAULT);
      fault         <= (state_d == S_FAULT);
      fault_code    <= code_d;
    end
  end

endmodule

// File: doc/drive_sequencer.md
Name: drive_sequencer

Overview:
- Sequences one drive burst of the coil: gate-driver enable, signal-generator run/hold, and handoff from the open-loop start period to the closed-loop period from the frequency counter.
- Enforces a maximum on-time and a minimum off-time, and latches faults on lost or invalid feedback.
- Sits between the interrupter/fire request and the signal generator, frequency counter and gate-driver enable, all in the system_clock domain.

Parameters:
- ON_CYCLES_MAX, 20000, maximum cycles in ARM+OPEN_LOOP+LOCKED per burst
- OFF_CYCLES_MIN, 200000, minimum cycles in COOLDOWN before the next burst
- ARM_CYCLES, 16, cycles between driver enable and generator run
- LOCK_TIMEOUT, 2000, cycles in OPEN_LOOP without period_valid before a fault
- PERIOD_MIN, 20, smallest accepted measured period
- PERIOD_MAX, 200, largest accepted measured period

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fire  in  1  level burst request (interrupter output)
- fault_clear  in  1  one-cycle pulse, clears a latched fault
- period_in  in  32  measured period from the frequency counter
- period_valid  in  1  period_in valid strobe
- driver_enable  out  1  gate-driver enable
- gen_run  out  1  high = generator and counter run; low = held in reset
- period_set  out  1  one-cycle load strobe to the generator
- period_out  out  32  period to load
- busy  out  1  high outside IDLE and FAULT
- fault  out  1  latched fault
- fault_code  out  2  0 none, 1 lock timeout, 2 period out of range

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. State after reset is IDLE, and all counters are cleared.
- States: IDLE, ARM, OPEN_LOOP, LOCKED, COOLDOWN, FAULT.
- IDLE:
  - driver_enable=0, gen_run=0.
  - fire=1 -> ARM; the on-counter clears to 0.
- ARM:
  - driver_enable=1, gen_run=0.
  - After ARM_CYCLES cycles -> OPEN_LOOP.
- OPEN_LOOP:
  - driver_enable=1, gen_run=1; the generator runs at its built-in initial period.
  - First accepted period_valid -> LOCKED, with period_set=1 and period_out=period_in on the next cycle.
  - LOCK_TIMEOUT cycles elapse with no valid period -> FAULT, fault_code=1.
- LOCKED:
  - driver_enable=1, gen_run=1.
  - Each accepted period_valid produces period_set=1 and updates period_out one cycle later.
- On-counter:
  - Counts every cycle in ARM, OPEN_LOOP and LOCKED.
  - fire=0, or on-counter reaching ON_CYCLES_MAX -> COOLDOWN. Exit is in the same cycle the condition is seen; driver_enable and gen_run go low on the next edge.
- COOLDOWN:
  - All outputs low except busy.
  - The off-counter runs to OFF_CYCLES_MIN, then -> IDLE.
  - fire held high through COOLDOWN starts the next burst one cycle after entering IDLE.
- FAULT:
  - driver_enable=0, gen_run=0, fault=1, fault_code held.
  - fault_clear=1 -> COOLDOWN, so the full off-time is enforced; fault and fault_code clear on the same edge.
  - fault_clear outside FAULT is ignored.
- Simultaneous events:
  - In OPEN_LOOP, period_valid wins over timeout expiry in the same cycle.
  - On-time limit or fire=0 wins over period_valid: no period_set is issued.
  - A fault wins over fire=0 in the same cycle.
- period_valid is ignored in IDLE, ARM, COOLDOWN and FAULT.
- Counters are at least 32 bits wide and saturate; they never wrap.
- Reset mid-burst: outputs go to 0 on the next edge. No cooldown is enforced after reset.

Optional Feature:
- PERIOD_RANGE_CHECK_EN defined:
  - A period_valid with period_in < PERIOD_MIN or > PERIOD_MAX in OPEN_LOOP or LOCKED -> FAULT, fault_code=2, and no period_set.
  - Bounds are inclusive.
- Undefined: every period_valid is accepted, and fault_code=2 never occurs.

Test Plan:
- ARM_CYCLES=16: fire=1 at cycle 0 -> driver_enable=1 at cycle 1, gen_run=1 at cycle 17; period_valid with period_in=56 at cycle 30 -> period_set=1 and period_out=56 at cycle 31, state LOCKED.
- fire held high, period_valid every 100 cycles -> driver_enable drops exactly ON_CYCLES_MAX cycles after leaving IDLE; no new burst before OFF_CYCLES_MIN cooldown cycles have elapsed.
- fire=1 with no period_valid -> fault=1, fault_code=1, driver_enable=0 at ARM_CYCLES+LOCK_TIMEOUT+1; fault_clear pulse -> COOLDOWN, fault=0, then IDLE after OFF_CYCLES_MIN.
- With PERIOD_RANGE_CHECK_EN, period_in=19 in LOCKED -> fault_code=2, no period_set. Without it, the same stimulus -> period_set=1 and period_out=19.
- fire deasserted in the same cycle as period_valid in LOCKED -> no period_set; COOLDOWN entered, driver_enable=0 next cycle.
- reset asserted during LOCKED -> all outputs 0 next edge; fire=1 right after reset -> ARM one cycle after reset deasserts.
